// File: rtl/reg_wr_merge_fpga.sv
// Merges two register-file write ports into one block-RAM write port, queueing collisions.
// Optional macro REG_WR_MERGE_OVF_CHK_EN adds a sticky ovf output for discarded writes.
module reg_wr_merge_fpga #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
`ifdef REG_WR_MERGE_OVF_CHK_EN
    output logic                       ovf,
`endif
    output logic [$clog2(DEPTH):0]     pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t              mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next, free;
    wr_t              w0, w1, issue, rem0, rem1;
    logic             issue_v, pop, rem0_v, rem1_v, acc0, acc1, drop;
    logic [1:0]       n_push;

    assign w0 = '{addr: wr0_addr, data: wr0_data};
    assign w1 = '{addr: wr1_addr, data: wr1_data};

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        pop     = 1'b0;
        issue_v = 1'b0;
        issue   = w0;
        rem0_v  = 1'b0;
        rem0    = w0;
        rem1_v  = 1'b0;
        rem1    = w1;
        if (count != '0) begin
            pop     = 1'b1;
            issue_v = 1'b1;
            issue   = mem[rd_ptr];
            rem0_v  = wr0_en | wr1_en;
            rem0    = wr0_en ? w0 : w1;
            rem1_v  = wr0_en & wr1_en;
        end else if (wr0_en) begin
            issue_v = 1'b1;
            rem0_v  = wr1_en;
            rem0    = w1;
        end else if (wr1_en) begin
            issue_v = 1'b1;
            issue   = w1;
        end
        // Room left after this cycle's pop; rem1 is only valid when rem0 is.
        free       = CNT_W'(DEPTH) - count + CNT_W'(pop);
        acc0       = rem0_v && (free >= CNT_W'(1));
        acc1       = rem1_v && (free >= CNT_W'(2));
        n_push     = {1'b0, acc0} + {1'b0, acc1};
        drop       = (rem0_v & ~acc0) | (rem1_v & ~acc1);
        count_next = count - CNT_W'(pop) + CNT_W'(n_push);
    end

    // NOTE: the queue storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= rem0;
        if (acc1) mem[wr_ptr + PTR_W'(1)] <= rem1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else begin
            wr_en <= issue_v;
            if (issue_v) begin
                wr_addr <= issue.addr;
                wr_data <= issue.data;
            end
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count_next;
            busy   <= count_next > CNT_W'(DEPTH - 2);
        end
    end

    assign pending = count;

`ifdef REG_WR_MERGE_OVF_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && drop)
            $warning("reg_wr_merge_fpga: write dropped, addr=%0h",
                     (rem1_v && !acc1 && acc0) ? rem1.addr : rem0.addr);
    end
`endif
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_reg_wr_merge_fpga.sv
// Randomized and directed bench for reg_wr_merge_fpga against a queue-based reference model.
module tb_reg_wr_merge_fpga;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr0_en, wr1_en;
    logic [ADDR_W-1:0]       wr0_addr, wr1_addr;
    logic [DATA_W-1:0]       wr0_data, wr1_data;
    logic                    wr_en, busy;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [$clog2(DEPTH):0]  pending;
`ifdef REG_WR_MERGE_OVF_CHK_EN
    logic                    ovf;
`endif

    reg_wr_merge_fpga #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy),
`ifdef REG_WR_MERGE_OVF_CHK_EN
        .ovf(ovf),
`endif
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus the expected output registers.
    ent_t              mq[$];
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_drops;
    logic [DATA_W-1:0] m_regs [128];
    logic [DATA_W-1:0] d_regs [128];
    int                checks = 0;
    int                failures = 0;

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Apply one cycle of inputs, advance model and DUT, return at posedge+1.
    task automatic cycle(input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        ent_t c[$];
        wr0_en = e0; wr0_addr = a0; wr0_data = d0;
        wr1_en = e1; wr1_addr = a1; wr1_data = d1;
        @(posedge clk);
        if (mq.size() > 0) c.push_back(mq.pop_front());
        if (e0) c.push_back('{addr: a0, data: d0});
        if (e1) c.push_back('{addr: a1, data: d1});
        m_en = (c.size() > 0);
        if (m_en) begin
            m_addr = c[0].addr;
            m_data = c[0].data;
            m_regs[m_addr] = m_data;
            for (int i = 1; i < c.size(); i++) begin
                if (mq.size() < DEPTH) mq.push_back(c[i]);
                else m_drops++;
            end
        end
        #1;
        if (wr_en) d_regs[wr_addr] = wr_data;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr0_en = 1'b0; wr1_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
        #3;
        checks++;
        if (wr_en !== 1'b0 || pending !== 0 || busy !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
            failures++;
            $display("FAIL reset_initial: wr_en=%b pending=%0d busy=%b addr=%h data=%h, want 0 0 0 0 0",
                     wr_en, pending, busy, wr_addr, wr_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 7'h03, 32'h11, 1'b1, 7'h04, 32'h22);
        checks++;
        if (pending !== 1) begin
            failures++;
            $display("FAIL reset_prefill: pending=%0d want 1", pending);
        end
        #1;
        wr0_en = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || pending !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: wr_en=%b pending=%0d busy=%b, want 0 0 0", wr_en, pending, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle();
        checks++;
        if (wr_en !== 1'b0 || pending !== 0) begin
            failures++;
            $display("FAIL reset_discard: wr_en=%b pending=%0d, want 0 0", wr_en, pending);
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 7'h05, 32'hDEAD_BEEF, 1'b0, '0, '0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h05 || wr_data !== 32'hDEAD_BEEF || pending !== 0) begin
            failures++;
            $display("FAIL single_issue: en=%b addr=%h data=%h pending=%0d, want 1 05 deadbeef 0",
                     wr_en, wr_addr, wr_data, pending);
        end
        idle();
        checks++;
        if (wr_en !== 1'b0 || pending !== 0 || wr_addr !== 7'h05 || wr_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_idle: en=%b pending=%0d addr=%h data=%h, want 0 0 05 deadbeef",
                     wr_en, pending, wr_addr, wr_data);
        end
    endtask

    task automatic test_collision();
        cycle(1'b1, 7'h10, 32'h1, 1'b1, 7'h10, 32'h2);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h10 || wr_data !== 32'h1 || pending !== 1) begin
            failures++;
            $display("FAIL collision_first: en=%b addr=%h data=%h pending=%0d, want 1 10 1 1",
                     wr_en, wr_addr, wr_data, pending);
        end
        idle();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 7'h10 || wr_data !== 32'h2 || pending !== 0) begin
            failures++;
            $display("FAIL collision_second: en=%b addr=%h data=%h pending=%0d, want 1 10 2 0",
                     wr_en, wr_addr, wr_data, pending);
        end
        checks++;
        if (d_regs[7'h10] !== 32'h2) begin
            failures++;
            $display("FAIL collision_final: reg=%h want 2", d_regs[7'h10]);
        end
    endtask

    task automatic test_burst();
        int exp_pend[6] = '{1, 2, 3, 2, 1, 0};
        logic exp_busy[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            if (k < 3)
                cycle(1'b1, 7'(7'h20 + 2 * k), 32'h100 + 2 * k,
                      1'b1, 7'(7'h21 + 2 * k), 32'h101 + 2 * k);
            else
                idle();
            checks++;
            if (wr_en !== 1'b1 || wr_data !== 32'h100 + k || pending !== exp_pend[k] || busy !== exp_busy[k]) begin
                failures++;
                $display("FAIL burst_%0d: en=%b data=%h pending=%0d busy=%b, want 1 %h %0d %b",
                         k, wr_en, wr_data, pending, busy, 32'h100 + k, exp_pend[k], exp_busy[k]);
            end
        end
    endtask

    task automatic test_interleave();
        logic [DATA_W-1:0] exp_d[3] = '{32'hC, 32'hD, 32'hA5A5_A5A5};
        logic [ADDR_W-1:0] exp_a[3] = '{7'h0C, 7'h0D, 7'h7F};
        cycle(1'b1, 7'h0A, 32'hA, 1'b1, 7'h0B, 32'hB);
        cycle(1'b1, 7'h0C, 32'hC, 1'b1, 7'h0D, 32'hD);
        checks++;
        if (pending !== 2) begin
            failures++;
            $display("FAIL interleave_fill: pending=%0d want 2", pending);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 0) cycle(1'b0, '0, '0, 1'b1, 7'h7F, 32'hA5A5_A5A5);
            else idle();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== exp_a[k] || wr_data !== exp_d[k]) begin
                failures++;
                $display("FAIL interleave_%0d: en=%b addr=%h data=%h, want 1 %h %h",
                         k, wr_en, wr_addr, wr_data, exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic e0, e1;
            logic busy_m;
            busy_m = mq.size() > DEPTH - 2;
            e0 = !busy_m && ($urandom_range(0, 3) != 0);
            e1 = !busy_m && ($urandom_range(0, 2) != 0);
            cycle(e0, 7'($urandom_range(0, 7)), $urandom(), e1, 7'($urandom_range(0, 7)), $urandom());
            checks++;
            if (wr_en !== m_en || (m_en && (wr_addr !== m_addr || wr_data !== m_data)) ||
                pending !== mq.size() || busy !== (mq.size() > DEPTH - 2)) begin
                failures++;
                $display("FAIL random_%0d: en=%b addr=%h data=%h pending=%0d busy=%b, want %b %h %h %0d %b",
                         n, wr_en, wr_addr, wr_data, pending, busy, m_en, m_addr, m_data, mq.size(),
                         mq.size() > DEPTH - 2);
            end
        end
        for (int k = 0; k < 10; k++) idle();
        checks++;
        if (pending !== 0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL random_drain: pending=%0d en=%b, want 0 0", pending, wr_en);
        end
        for (int a = 0; a < 8; a++) begin
            checks++;
            if (d_regs[a] !== m_regs[a]) begin
                failures++;
                $display("FAIL random_reg_%0d: got %h want %h", a, d_regs[a], m_regs[a]);
            end
        end
    endtask

`ifdef REG_WR_MERGE_OVF_CHK_EN
    task automatic test_ovf();
        for (int k = 0; k < 5; k++)
            cycle(1'b1, 7'(7'h40 + 2 * k), 32'h200 + 2 * k, 1'b1, 7'(7'h41 + 2 * k), 32'h201 + 2 * k);
        checks++;
        if (ovf !== 1'b1 || pending !== 4 || m_drops == 0) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b pending=%0d model_drops=%0d, want 1 4 >0", ovf, pending, m_drops);
        end
        for (int k = 0; k < 6; k++) begin
            idle();
            checks++;
            if (ovf !== 1'b1 || wr_en !== m_en || (m_en && wr_data !== m_data) || pending !== mq.size()) begin
                failures++;
                $display("FAIL ovf_drain_%0d: ovf=%b en=%b data=%h pending=%0d, want 1 %b %h %0d",
                         k, ovf, wr_en, wr_data, pending, m_en, m_data, mq.size());
            end
        end
    endtask
`endif

    initial begin
        m_drops = 0;
        for (int a = 0; a < 128; a++) begin
            m_regs[a] = '0;
            d_regs[a] = '0;
        end
        test_reset();
        test_single();
        test_collision();
        test_burst();
        test_interleave();
        test_random();
`ifdef REG_WR_MERGE_OVF_CHK_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
